// File: rtl/bus_traffic_gen.sv
// Scripted write-then-readback traffic source for a bus master device port.
// Define TGEN_LFSR_DATA_EN to use Galois-LFSR word data instead of seed+i.
module bus_traffic_gen #(
  parameter int unsigned ADDR_WIDTH           = 16,
  parameter int unsigned DATA_WIDTH           = 8,
  parameter int unsigned SLAVE_MEM_ADDR_WIDTH = 12,
  parameter int unsigned NUM_WORDS            = 16,
  parameter int unsigned TIMEOUT_CYCLES       = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [DATA_WIDTH-1:0] dwdata,
  input  logic [DATA_WIDTH-1:0] drdata,
  output logic [ADDR_WIDTH-1:0] daddr,
  output logic                  dvalid,
  input  logic                  dready,
  output logic                  dmode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int unsigned OFF_W = SLAVE_MEM_ADDR_WIDTH;
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_seen_q, busy_seen_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  dvalid_d, dmode_d, busy_d, done_d, pass_d, timeout_d;
  logic [ADDR_WIDTH-1:0] daddr_d, first_err_d;
  logic [DATA_WIDTH-1:0] dwdata_d, exp_word;
  logic [7:0]            err_d;

  logic in_phase, complete, expired, last, abort;

  // Offset wraps inside the selected slave; slave-select bits pass through untouched.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] b,
                                                      input logic [IDX_W-1:0]      i);
    logic [OFF_W-1:0] off;
    off = b[OFF_W-1:0] + OFF_W'(i);
    return {b[ADDR_WIDTH-1:OFF_W], off};
  endfunction

`ifdef TGEN_LFSR_DATA_EN
  // x^8+x^6+x^5+x^4+1 for 8-bit words; other widths fall back to a top-bit-only tap.
  localparam logic [DATA_WIDTH-1:0] LFSR_TAPS =
    (DATA_WIDTH == 8) ? DATA_WIDTH'(8'hB8) : {1'b1, (DATA_WIDTH-1)'(0)};

  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;

  function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_TAPS) : (x >> 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lfsr_load(input logic [DATA_WIDTH-1:0] s);
    return (s == '0) ? DATA_WIDTH'(1) : s;
  endfunction

  assign exp_word = lfsr_q;
`else
  assign exp_word = seed_q + DATA_WIDTH'(idx_q);
`endif

  assign in_phase = (state == S_WR_REQ) || (state == S_WR_WAIT) ||
                    (state == S_RD_REQ) || (state == S_RD_WAIT);
  assign complete = busy_seen_q && dready;
  assign expired  = (cnt_q == CNT_LAST);
  assign last     = (idx_q == LAST_IDX);
  assign abort    = in_phase && (state_next == S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; progress wins over an expiring timeout in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_WR_REQ;
      S_WR_REQ:  if (dready) state_next = S_WR_WAIT;
                 else if (expired) state_next = S_IDLE;
      S_WR_WAIT: if (complete) state_next = last ? S_RD_REQ : S_WR_REQ;
                 else if (expired) state_next = S_IDLE;
      S_RD_REQ:  if (dready) state_next = S_RD_WAIT;
                 else if (expired) state_next = S_IDLE;
      S_RD_WAIT: if (complete) state_next = S_CHECK;
                 else if (expired) state_next = S_IDLE;
      S_CHECK:   state_next = last ? S_DONE : S_RD_REQ;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output and datapath next values, registered below.
  always_comb begin
    idx_d       = idx_q;
    base_d      = base_q;
    seed_d      = seed_q;
    busy_seen_d = busy_seen_q;
    rdata_d     = rdata_q;
    done_d      = done;
    pass_d      = pass;
    timeout_d   = timeout;
    err_d       = err_count;
    first_err_d = first_err_addr;
`ifdef TGEN_LFSR_DATA_EN
    lfsr_d      = lfsr_q;
`endif
    cnt_d = (in_phase && (state_next == state)) ? cnt_q + CNT_W'(1) : '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          seed_d      = seed;
          idx_d       = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          err_d       = '0;
          first_err_d = '0;
`ifdef TGEN_LFSR_DATA_EN
          lfsr_d      = lfsr_load(seed);
`endif
        end
      end
      S_WR_REQ, S_RD_REQ: busy_seen_d = 1'b0;
      S_WR_WAIT: begin
        if (!dready) busy_seen_d = 1'b1;
        if (complete) begin
          if (last) begin
            idx_d = '0;
`ifdef TGEN_LFSR_DATA_EN
            lfsr_d = lfsr_load(seed_q);
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
`ifdef TGEN_LFSR_DATA_EN
            lfsr_d = lfsr_step(lfsr_q);
`endif
          end
        end
      end
      S_RD_WAIT: begin
        if (!dready) busy_seen_d = 1'b1;
        if (complete) rdata_d = drdata;
      end
      S_CHECK: begin
        if (rdata_q != exp_word) begin
          if (err_count != 8'hFF) err_d = err_count + 8'd1;
          if (err_count == 8'd0)  first_err_d = word_addr(base_q, idx_q);
        end
        if (!last) begin
          idx_d = idx_q + IDX_W'(1);
`ifdef TGEN_LFSR_DATA_EN
          lfsr_d = lfsr_step(lfsr_q);
`endif
        end
      end
      default: ;
    endcase

    if (state_next == S_DONE) begin
      done_d = 1'b1;
      pass_d = (err_d == 8'd0);
    end
    if (abort) begin
      timeout_d = 1'b1;
      done_d    = 1'b1;
      pass_d    = 1'b0;
    end

    dvalid_d = (state_next == S_WR_REQ) || (state_next == S_RD_REQ);
    dmode_d  = (state_next == S_WR_REQ) || (state_next == S_WR_WAIT);
    busy_d   = (state_next != S_IDLE) && (state_next != S_DONE);
    daddr_d  = word_addr(base_d, idx_d);
`ifdef TGEN_LFSR_DATA_EN
    dwdata_d = lfsr_d;
`else
    dwdata_d = seed_d + DATA_WIDTH'(idx_d);
`endif
  end

  // Register bank; reset drops dvalid immediately and abandons any run.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q          <= '0;
      base_q         <= '0;
      seed_q         <= '0;
      cnt_q          <= '0;
      busy_seen_q    <= 1'b0;
      rdata_q        <= '0;
      dvalid         <= 1'b0;
      dmode          <= 1'b0;
      daddr          <= '0;
      dwdata         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
`ifdef TGEN_LFSR_DATA_EN
      lfsr_q         <= '0;
`endif
    end else begin
      idx_q          <= idx_d;
      base_q         <= base_d;
      seed_q         <= seed_d;
      cnt_q          <= cnt_d;
      busy_seen_q    <= busy_seen_d;
      rdata_q        <= rdata_d;
      dvalid         <= dvalid_d;
      dmode          <= dmode_d;
      daddr          <= daddr_d;
      dwdata         <= dwdata_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      timeout        <= timeout_d;
      err_count      <= err_d;
      first_err_addr <= first_err_d;
`ifdef TGEN_LFSR_DATA_EN
      lfsr_q         <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_traffic_gen.sv
// Directed bench for bus_traffic_gen with a 3-cycle-latency slave model.
module tb_bus_traffic_gen;

  logic        clk = 1'b0;
  logic        rstn, start, dvalid, dready, dmode, busy, done, pass, timeout;
  logic [15:0] base_addr, daddr, first_err_addr;
  logic [7:0]  seed, dwdata, drdata, err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_traffic_gen #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .SLAVE_MEM_ADDR_WIDTH(12),
    .NUM_WORDS(16), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .seed(seed),
    .dwdata(dwdata), .drdata(drdata), .daddr(daddr), .dvalid(dvalid),
    .dready(dready), .dmode(dmode), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic        mode;
    logic [7:0]  data;
  } req_t;

  req_t        log_q[$];
  logic [7:0]  mem [0:65535];
  logic        stall, corrupt, pending, p_mode;
  logic [15:0] p_addr;
  logic [7:0]  p_data;
  int          lat;

  // Slave: accept, hold dready low for 3 cycles, then complete; optional stall/corruption.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dready  <= 1'b1;
      pending <= 1'b0;
      lat     <= 0;
      drdata  <= 8'h00;
    end else if (pending) begin
      if (lat > 1) lat <= lat - 1;
      else if (!stall) begin
        if (p_mode) mem[p_addr] <= p_data;
        else drdata <= mem[p_addr] ^
          ((corrupt && (p_addr == 16'h1005 || p_addr == 16'h1009)) ? 8'h01 : 8'h00);
        dready  <= 1'b1;
        pending <= 1'b0;
      end
    end else if (dvalid && dready) begin
      log_q.push_back('{addr: daddr, mode: dmode, data: dwdata});
      pending <= 1'b1;
      dready  <= 1'b0;
      lat     <= 3;
      p_addr  <= daddr;
      p_mode  <= dmode;
      p_data  <= dwdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_word(input logic [7:0] s, input int k);
    logic [7:0] x;
`ifdef TGEN_LFSR_DATA_EN
    x = (s == 8'h00) ? 8'h01 : s;
    for (int j = 0; j < k; j++) x = x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
`else
    x = s + 8'(k);
`endif
    return x;
  endfunction

  task automatic start_run(input logic [15:0] b, input logic [7:0] s);
    log_q.delete();
    @(negedge clk);
    base_addr = b;
    seed      = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  // 16 writes then 16 reads of the same wrapped addresses.
  task automatic check_log(input string tag, input logic [15:0] b, input logic [7:0] s);
    chk({tag, "_log_len"}, 32'(log_q.size()), 32);
    for (int k = 0; k < 32 && k < log_q.size(); k++) begin
      int         w;
      logic [11:0] off;
      w   = k % 16;
      off = b[11:0] + 12'(w);
      chk($sformatf("%s_req%0d_addr", tag, k), 32'(log_q[k].addr), 32'({b[15:12], off}));
      chk($sformatf("%s_req%0d_mode", tag, k), 32'(log_q[k].mode), (k < 16) ? 1 : 0);
      if (k < 16)
        chk($sformatf("%s_req%0d_data", tag, k), 32'(log_q[k].data), 32'(exp_word(s, w)));
    end
  endtask

  initial begin
    int n;
    rstn = 1'b0; start = 1'b0; base_addr = 16'h0000; seed = 8'h00;
    stall = 1'b0; corrupt = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_dvalid", 32'(dvalid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_first_err", 32'(first_err_addr), 0);
    chk("rst_daddr", 32'(daddr), 0);
    chk("rst_dwdata", 32'(dwdata), 0);
    chk("rst_dmode", 32'(dmode), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Clean run at 0x1000, seed 0x20.
    start_run(16'h1000, 8'h20);
    chk("clean_busy_running", 32'(busy), 1);
    chk("clean_first_daddr", 32'(daddr), 32'h1000);
    wait_done(2000);
    chk("clean_done", 32'(done), 1);
    chk("clean_pass", 32'(pass), 1);
    chk("clean_err_count", 32'(err_count), 0);
    chk("clean_timeout", 32'(timeout), 0);
    @(negedge clk);
    chk("clean_busy_after", 32'(busy), 0);
    chk("clean_dvalid_after", 32'(dvalid), 0);
    check_log("clean", 16'h1000, 8'h20);
    chk("clean_mem_100f", 32'(mem[16'h100F]), 32'(exp_word(8'h20, 15)));

    // Offset wrap inside slave 2.
    start_run(16'h2FFE, 8'h55);
    wait_done(2000);
    chk("wrap_pass", 32'(pass), 1);
    check_log("wrap", 16'h2FFE, 8'h55);
    if (log_q.size() >= 4) begin
      chk("wrap_addr1", 32'(log_q[1].addr), 32'h2FFF);
      chk("wrap_addr2", 32'(log_q[2].addr), 32'h2000);
      chk("wrap_addr3", 32'(log_q[3].addr), 32'h2001);
    end

    // Readback corruption at 0x1005 and 0x1009.
    corrupt = 1'b1;
    start_run(16'h1000, 8'h20);
    wait_done(2000);
    corrupt = 1'b0;
    chk("corrupt_done", 32'(done), 1);
    chk("corrupt_err_count", 32'(err_count), 2);
    chk("corrupt_first_err", 32'(first_err_addr), 32'h1005);
    chk("corrupt_pass", 32'(pass), 0);
    chk("corrupt_timeout", 32'(timeout), 0);

    // Start pulse while busy must be ignored.
    start_run(16'h1000, 8'h20);
    n = 0;
    while (log_q.size() < 1 && n < 100) begin @(negedge clk); n++; end
    chk("ignore_first_accept", 32'(log_q.size() >= 1), 1);
    @(negedge clk);
    base_addr = 16'h3000; seed = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    chk("ignore_pass", 32'(pass), 1);
    chk("ignore_final_daddr", 32'(daddr), 32'h100F);
    check_log("ignore", 16'h1000, 8'h20);

    // Asynchronous reset in the middle of the read phase.
    start_run(16'h1000, 8'h20);
    n = 0;
    while (!(dvalid && !dmode && log_q.size() >= 20) && n < 2000) begin @(negedge clk); n++; end
    chk("midrd_reached_read", 32'(dvalid && !dmode), 1);
    #1 rstn = 1'b0;
    #1;
    chk("midrd_dvalid_async", 32'(dvalid), 0);
    chk("midrd_busy", 32'(busy), 0);
    chk("midrd_daddr", 32'(daddr), 0);
    chk("midrd_dmode", 32'(dmode), 0);
    chk("midrd_done", 32'(done), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    start_run(16'h1100, 8'h0A);
    wait_done(2000);
    chk("after_rst_done", 32'(done), 1);
    chk("after_rst_pass", 32'(pass), 1);
    check_log("after_rst", 16'h1100, 8'h0A);

`ifdef TGEN_LFSR_DATA_EN
    start_run(16'h1200, 8'h00);
    wait_done(2000);
    chk("lfsr_pass", 32'(pass), 1);
    if (log_q.size() >= 2) begin
      chk("lfsr_word0", 32'(log_q[0].data), 32'h01);
      chk("lfsr_word1", 32'(log_q[1].data), 32'hB8);
    end
`endif

    // Slave stalls after the first acceptance.
    stall = 1'b1;
    start_run(16'h1000, 8'h20);
    n = 0;
    while (!timeout && n < 6000) begin @(negedge clk); n++; end
    chk("stall_cycles_window", 32'(n >= 4090 && n <= 4105), 1);
    chk("stall_timeout", 32'(timeout), 1);
    chk("stall_done", 32'(done), 1);
    chk("stall_pass", 32'(pass), 0);
    chk("stall_dvalid", 32'(dvalid), 0);
    chk("stall_busy", 32'(busy), 0);
    chk("stall_accepts", 32'(log_q.size()), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
